// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the RV32M iterative
//                multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Number of shift/add or shift/subtract iterations per operation
    localparam int ITER    = 32;
    // Width of the iteration counter
    localparam int c_CNT_W = $clog2(ITER);

    // funct3 encodings of the M-extension instructions
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } e_muldiv_op;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } e_muldiv_state;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic f_is_div(input e_muldiv_op op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Ops that interpret rs1 as signed
    function automatic logic f_a_signed(input e_muldiv_op op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Ops that interpret rs2 as signed
    function automatic logic f_b_signed(input e_muldiv_op op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_addsub
//  Description : 33-bit adder/subtractor shared by the multiply and divide
//                iterations. o_borrow is set when a subtraction underflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_addsub (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    input  logic        i_sub,
    output logic [32:0] o_sum,
    output logic        o_borrow
);

    logic [32:0] w_b_inv;
    logic [33:0] w_full;

    // Subtraction as a + ~b + 1; a missing carry-out means a borrow
    always_comb begin
        w_b_inv  = i_sub ? ~i_b : i_b;
        w_full   = {1'b0, i_a} + {1'b0, w_b_inv} + {33'd0, i_sub};
        o_sum    = w_full[32:0];
        o_borrow = i_sub & ~w_full[33];
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer. Shift-add multiply
//                and restoring divide over one shared 33-bit add/subtract
//                datapath; stalls the pipeline until the result is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] operand_a_i,
    input  logic [DW-1:0] operand_b_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] result_o
);

    localparam logic [DW-1:0] c_INT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Registered state
    e_muldiv_state        r_state_q;
    e_muldiv_op           r_op_q;
    logic [DW-1:0]        r_a_q;        // raw dividend / multiplier as captured
    logic [DW-1:0]        r_b_q;        // raw rs2, then its magnitude from PREP on
    logic [DW-1:0]        r_hi_q;       // product high half / partial remainder
    logic [DW-1:0]        r_lo_q;       // product low half  / quotient
    logic [c_CNT_W-1:0]   r_cnt_q;
    logic                 r_neg_res_q;  // product or quotient is negative
    logic                 r_neg_rem_q;  // remainder is negative
    logic [DW-1:0]        r_result_q;

    // Next-state values
    e_muldiv_state        w_state_d;
    e_muldiv_op           w_op_d;
    logic [DW-1:0]        w_a_d;
    logic [DW-1:0]        w_b_d;
    logic [DW-1:0]        w_hi_d;
    logic [DW-1:0]        w_lo_d;
    logic [c_CNT_W-1:0]   w_cnt_d;
    logic                 w_neg_res_d;
    logic                 w_neg_rem_d;
    logic [DW-1:0]        w_result_d;

    // Shared adder hookup
    logic [DW:0]          w_add_a;
    logic [DW:0]          w_add_b;
    logic                 w_add_sub;
    logic [DW:0]          w_add_sum;
    logic                 w_add_borrow;

    // PREP and FIX helpers
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [DW-1:0]        w_a_abs;
    logic [DW-1:0]        w_b_abs;
    logic                 w_is_div;
    logic [2*DW-1:0]      w_prod_fix;
    logic [DW-1:0]        w_quot_fix;
    logic [DW-1:0]        w_rem_fix;

    muldiv_addsub u_addsub (
        .i_a      (w_add_a),
        .i_b      (w_add_b),
        .i_sub    (w_add_sub),
        .o_sum    (w_add_sum),
        .o_borrow (w_add_borrow)
    );

    // Operand magnitudes, sign fix-up and the adder input mux
    always_comb begin
        w_is_div   = f_is_div(r_op_q);
        w_a_neg    = f_a_signed(r_op_q) & r_a_q[DW-1];
        w_b_neg    = f_b_signed(r_op_q) & r_b_q[DW-1];
        w_a_abs    = w_a_neg ? -r_a_q : r_a_q;
        w_b_abs    = w_b_neg ? -r_b_q : r_b_q;
        w_prod_fix = r_neg_res_q ? -{r_hi_q, r_lo_q} : {r_hi_q, r_lo_q};
        w_quot_fix = r_neg_res_q ? -r_lo_q : r_lo_q;
        w_rem_fix  = r_neg_rem_q ? -r_hi_q : r_hi_q;
        if (w_is_div) begin
            // Trial subtract of the divisor from the left-shifted remainder
            w_add_a   = {r_hi_q, r_lo_q[DW-1]};
            w_add_b   = {1'b0, r_b_q};
            w_add_sub = 1'b1;
        end else begin
            // Add the multiplicand only when the current multiplier bit is set
            w_add_a   = {1'b0, r_hi_q};
            w_add_b   = r_lo_q[0] ? {1'b0, r_b_q} : '0;
            w_add_sub = 1'b0;
        end
    end

    // Next-state logic for the FSM and the datapath registers
    always_comb begin
        w_state_d   = r_state_q;
        w_op_d      = r_op_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_hi_d      = r_hi_q;
        w_lo_d      = r_lo_q;
        w_cnt_d     = r_cnt_q;
        w_neg_res_d = r_neg_res_q;
        w_neg_rem_d = r_neg_rem_q;
        w_result_d  = r_result_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_d = ST_PREP;
                    w_op_d    = e_muldiv_op'(funct3_i);
                    w_a_d     = operand_a_i;
                    w_b_d     = operand_b_i;
                end
            end
            ST_PREP: begin
                w_cnt_d     = '0;
                w_hi_d      = '0;
                w_lo_d      = w_a_abs;
                w_b_d       = w_b_abs;
                w_neg_res_d = w_a_neg ^ w_b_neg;
                w_neg_rem_d = w_a_neg;
                if (w_is_div && (r_b_q == '0)) begin
                    // Divide by zero: all-ones quotient, remainder is the dividend
                    w_state_d  = ST_DONE;
                    w_result_d = r_op_q[1] ? r_a_q : '1;
                end else if (((r_op_q == OP_DIV) || (r_op_q == OP_REM)) &&
                             (r_a_q == c_INT_MIN) && (r_b_q == '1)) begin
                    // Signed overflow: quotient wraps to INT_MIN, remainder 0
                    w_state_d  = ST_DONE;
                    w_result_d = r_op_q[1] ? '0 : c_INT_MIN;
                end else begin
                    w_state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_is_div) begin
                    if (!w_add_borrow) begin
                        w_hi_d = w_add_sum[DW-1:0];
                        w_lo_d = {r_lo_q[DW-2:0], 1'b1};
                    end else begin
                        w_hi_d = w_add_a[DW-1:0];
                        w_lo_d = {r_lo_q[DW-2:0], 1'b0};
                    end
                end else begin
                    // Shift the 65-bit {carry, hi, lo} right by one
                    w_hi_d = w_add_sum[DW:1];
                    w_lo_d = {w_add_sum[0], r_lo_q[DW-1:1]};
                end
                w_cnt_d = r_cnt_q + c_CNT_W'(1);
                if (r_cnt_q == c_CNT_W'(ITER - 1)) begin
                    w_state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_d = ST_DONE;
                case (r_op_q)
                    OP_MUL:                        w_result_d = w_prod_fix[DW-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  w_result_d = w_prod_fix[2*DW-1:DW];
                    OP_DIV, OP_DIVU:               w_result_d = w_quot_fix;
                    default:                       w_result_d = w_rem_fix;
                endcase
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in IDLE; the last
        // delivered result is preserved.
        if (flush_i) begin
            w_state_d  = ST_IDLE;
            w_result_d = r_result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q   <= ST_IDLE;
            r_op_q      <= OP_MUL;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_hi_q      <= '0;
            r_lo_q      <= '0;
            r_cnt_q     <= '0;
            r_neg_res_q <= 1'b0;
            r_neg_rem_q <= 1'b0;
            r_result_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_op_q      <= w_op_d;
            r_a_q       <= w_a_d;
            r_b_q       <= w_b_d;
            r_hi_q      <= w_hi_d;
            r_lo_q      <= w_lo_d;
            r_cnt_q     <= w_cnt_d;
            r_neg_res_q <= w_neg_res_d;
            r_neg_rem_q <= w_neg_rem_d;
            r_result_q  <= w_result_d;
        end
    end

    // Stall is combinational so the instruction is held from its first EX cycle
    always_comb begin
        stall_o  = ((r_state_q == ST_IDLE) & start_i & ~flush_i) |
                   (r_state_q == ST_PREP) | (r_state_q == ST_CALC) |
                   (r_state_q == ST_FIX);
        busy_o   = (r_state_q != ST_IDLE);
        done_o   = (r_state_q == ST_DONE);
        result_o = r_result_q;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU in the execute stage. It accepts one operation from the pipeline and runs it over one shared 33-bit add/subtract datapath. A shift-add multiply or restoring divide takes 32 iterations. The block stalls the pipeline until the result is ready.

## Interface
- `DW`, 32, operand/result width; only 32 is supported.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  EX holds an M-extension instruction (opcode 0110011, funct7 0000001).
- `funct3_i`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a_i`  in  DW  rs1 value.
- `operand_b_i`  in  DW  rs2 value.
- `flush_i`  in  1  abort any operation in flight.
- `stall_o`  out  1  hold IF/ID/EX.
- `busy_o`  out  1  operation in flight.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid in that cycle.
- `result_o`  out  DW  result, held stable until the next accepted start.

## Operation
- States and transitions:
  - IDLE → PREP when `start_i` is high.
  - PREP → CALC normally; PREP → DONE for special cases.
  - CALC runs 32 iterations, counted by a 5-bit counter, then → FIX.
  - FIX → DONE.
  - DONE → IDLE, unconditionally.
- PREP:
  - Latch `funct3_i`.
  - Form absolute values. Signed operand: MULH takes both signed; MULHSU takes a signed, b unsigned; DIV and REM take both signed; all other ops are unsigned.
  - Record the result sign. Product and quotient are negative when operand signs differ. Remainder takes the dividend's sign.
- Multiply, CALC: 64-bit accumulator {hi, lo}. Each iteration adds |b| to hi if lo[0] is 1, then shifts the 65-bit value right by 1.
- Divide, CALC: restoring division. Each iteration shifts {rem, quot} left by 1 and trial-subtracts the divisor from rem. If no borrow, keep the difference and set quot[0] to 1.
- FIX: two's-complement negate the 64-bit product, quotient or remainder when its sign flag is set.
- Result select:
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Special cases, decided in PREP, skip CALC and FIX:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV/REM with 0x80000000 ÷ 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- The 33-bit adder is shared by multiply and divide; only one operation is ever in flight.
- `flush_i` moves any state to IDLE at the next edge with no `done_o`; `result_o` is unchanged. Flush has priority over `start_i`.
- `start_i` is ignored in every state other than IDLE.

## Timing
- Reset values: state IDLE; `stall_o`, `busy_o` and `done_o` 0; `result_o` 0; counter 0.
- `stall_o` = (IDLE & `start_i` & ~`flush_i`) | PREP | CALC | FIX. It is combinational, so the instruction stays in EX from its first cycle.
- `busy_o` = state ≠ IDLE.
- `done_o` = state is DONE. `stall_o` is 0 in DONE, so the pipeline captures `result_o` and advances in that cycle.
- Latency, with start sampled at edge 0:
  - PREP in cycle 1, CALC in cycles 2–33, FIX in cycle 34, DONE in cycle 35.
  - Special case: DONE in cycle 2.
- Back-to-back: the next M-instruction reaches EX in the cycle after DONE (IDLE) and starts immediately. There is no dead cycle beyond that.
- Reset asserted mid-operation returns all registers to reset values immediately; no `done_o` is produced.

## Structure
- `muldiv_pkg` holds:
  - typedef enum `e_muldiv_op` (3 bits) for the funct3 codes above;
  - typedef enum `e_muldiv_state` (IDLE, PREP, CALC, FIX, DONE);
  - localparam `ITER = 32`.
- One sub-module, `muldiv_addsub`: a 33-bit adder/subtractor with inputs a, b and sub, and outputs sum and borrow. It is instantiated once and muxed between multiply and divide.
- FSM, counter, operand and accumulator registers, sign logic and result select live in `muldiv_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start at cycle 0 → `stall_o` high in cycles 0–34; `done_o` in cycle 35 with `result_o` 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU on the same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → 0xFFFFFFFD; REM on the same operands → 0xFFFFFFFF; DIVU 100 ÷ 7 → 14; REMU 100 ÷ 7 → 2.
- DIVU 5 ÷ 0 → `done_o` in cycle 2 with 0xFFFFFFFF; REM 5 ÷ 0 → 5; DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- `flush_i` in cycle 10 of a DIV → `busy_o` low in cycle 11, no `done_o`, `result_o` unchanged. A new start in cycle 11 completes normally in cycle 46.
- `rst_ni` pulled low in cycle 20 of a MUL → outputs return to 0 immediately; no `done_o` after release.
